ub_affine_read_port: RTL

Read-side companion to the unified-buffer write path. It holds a single-bank RAM filled through a wen/addr/data write port. On a start pulse it walks a 4-level loop nest and computes the affine address OFFSET + sum(STRk * ctrl_vars[k]). It streams the read data, with matching ctrl_vars, to the consumer over a valid/ready handshake with full throughput and no data loss under backpressure.

---
 rtl/ub_affine_read_port_if.sv | 38 +++
 rtl/ub_affine_read_port.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ub_affine_read_port_if.sv
// Purpose: bus bundle for ub_affine_read_port (write port, sweep control,
//          output stream).
// Ports (signals):
//   flush          soft restart request
//   wen/waddr/wdata RAM write port
//   start          start-sweep pulse
//   busy/done      sweep status
//   out_valid/out_ready/out_data/out_ctrl_vars  output stream
//   err            sticky address-range error
// Modports: master = producer of requests / consumer of the stream,
//           slave  = the read port itself.
interface ub_affine_read_port_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 12
);
  logic                   flush;
  logic                   wen;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [3:0][15:0]       out_ctrl_vars;
  logic                   err;

  modport master (
    output flush, wen, waddr, wdata, start, out_ready,
    input  busy, done, out_valid, out_data, out_ctrl_vars, err
  );

  modport slave (
    input  flush, wen, waddr, wdata, start, out_ready,
    output busy, done, out_valid, out_data, out_ctrl_vars, err
  );
endinterface

// File: rtl/ub_affine_read_port.sv
// Purpose: affine-address read port for the unified buffer. A single-bank
//          RAM is filled through the write port; a start pulse sweeps a
//          4-level loop nest, reads RAM[OFFSET + sum(STRk*ctrl_vars[k])]
//          and streams data plus loop indices through a 2-entry FIFO.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    ub_affine_read_port_if.slave (write port, start/flush,
//          busy/done, out_* stream, err)
// Optional feature: define UB_RD_BOUNDS_CHECK_EN to build the sticky
//          out-of-range address error; otherwise err is tied low.
module ub_affine_read_port #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AW     = 12,
  parameter int unsigned EXT0   = 1,
  parameter int unsigned EXT1   = 4,
  parameter int unsigned EXT2   = 32,
  parameter int unsigned EXT3   = 32,
  parameter int unsigned STR0   = 0,
  parameter int unsigned STR1   = 1024,
  parameter int unsigned STR2   = 32,
  parameter int unsigned STR3   = 1,
  parameter int unsigned OFFSET = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ub_affine_read_port_if.slave   bus
);

  localparam int unsigned DEPTH = 32'd1 << AW;
  localparam int unsigned CVW   = 16;

  typedef logic [3:0][CVW-1:0] cv_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q;
  cv_t               cv_q;
  cv_t               cv_next_c;
  logic              busy_q;
  logic              done_q;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              inflight_q;
  logic [WIDTH-1:0]  rdata_q;
  cv_t               rcv_q;

  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              valid_q;
  logic [WIDTH-1:0]  head_data_q;
  logic [WIDTH-1:0]  tail_data_q;
  cv_t               head_cv_q;
  cv_t               tail_cv_q;

  logic              soft_clr_c;
  logic              pop_c;
  logic              push_c;
  logic [1:0]        credits_c;
  logic              issue_c;
  logic              last_c;
  logic [31:0]       addr32_c;
  logic [AW-1:0]     raddr_c;

  assign soft_clr_c = !rst_n || bus.flush;
  assign pop_c      = valid_q && bus.out_ready;
  assign push_c     = inflight_q;

  // Credits seen after this cycle's pop, so a beat leaving the FIFO frees
  // its slot for a same-cycle issue and the stream runs without bubbles.
  assign credits_c  = count_q + 2'(inflight_q) - 2'(pop_c);
  assign issue_c    = (state_q == RUN) && (credits_c < 2'd2);

  assign last_c = (cv_q[0] == CVW'(EXT0 - 1)) && (cv_q[1] == CVW'(EXT1 - 1)) &&
                  (cv_q[2] == CVW'(EXT2 - 1)) && (cv_q[3] == CVW'(EXT3 - 1));

  assign addr32_c = 32'(OFFSET) +
                    32'(STR0) * 32'(cv_q[0]) + 32'(STR1) * 32'(cv_q[1]) +
                    32'(STR2) * 32'(cv_q[2]) + 32'(STR3) * 32'(cv_q[3]);
  assign raddr_c  = addr32_c[AW-1:0];

  // Odometer: innermost index counts, wrapping ones carry outward.
  always_comb begin
    cv_next_c = cv_q;
    if (cv_q[3] == CVW'(EXT3 - 1)) begin
      cv_next_c[3] = '0;
      if (cv_q[2] == CVW'(EXT2 - 1)) begin
        cv_next_c[2] = '0;
        if (cv_q[1] == CVW'(EXT1 - 1)) begin
          cv_next_c[1] = '0;
          cv_next_c[0] = cv_q[0] + CVW'(1);
        end else begin
          cv_next_c[1] = cv_q[1] + CVW'(1);
        end
      end else begin
        cv_next_c[2] = cv_q[2] + CVW'(1);
      end
    end else begin
      cv_next_c[3] = cv_q[3] + CVW'(1);
    end
  end

  // Sweep control FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (soft_clr_c) begin
      state_q <= IDLE;
      cv_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            cv_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (issue_c) begin
            if (last_c) state_q <= DRAIN;
            else        cv_q    <= cv_next_c;
          end
        end
        DRAIN: begin
          if ((count_q == 2'd0) && !inflight_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM: write-first ordering is avoided, a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (bus.wen) mem[bus.waddr] <= bus.wdata;
    if (issue_c) begin
      rdata_q <= mem[raddr_c];
      rcv_q   <= cv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_clr_c) inflight_q <= 1'b0;
    else            inflight_q <= issue_c;
  end

  // 2-entry output FIFO; head register drives the output directly.
  assign count_d = count_q + 2'(push_c) - 2'(pop_c);

  always_ff @(posedge clk) begin
    if (soft_clr_c) begin
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    case ({push_c, pop_c})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_q <= rdata_q;
          head_cv_q   <= rcv_q;
        end else begin
          tail_data_q <= rdata_q;
          tail_cv_q   <= rcv_q;
        end
      end
      2'b01: begin
        head_data_q <= tail_data_q;
        head_cv_q   <= tail_cv_q;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_q <= rdata_q;
          head_cv_q   <= rcv_q;
        end else begin
          head_data_q <= tail_data_q;
          head_cv_q   <= tail_cv_q;
          tail_data_q <= rdata_q;
          tail_cv_q   <= rcv_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.out_valid     = valid_q;
  assign bus.out_data      = head_data_q;
  assign bus.out_ctrl_vars = head_cv_q;

`ifdef UB_RD_BOUNDS_CHECK_EN
  // Sticky range error: only reset clears it, flush keeps it.
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (issue_c && !bus.flush && (addr32_c >= 32'(DEPTH))) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr32_c[31:AW];
  assign bus.err        = 1'b0;
`endif

endmodule
